// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencing controller.
// Steps each instruction through fetch / decode / execute / memory / writeback,
// shares one memory port between fetch and data accesses via req/ack, and
// produces the datapath write enables, a memory watchdog, halt status and a
// retired-instruction counter.
//
// state   | code | meaning
// --------+------+-----------------------------------------------------------
// IDLE    |  0   | post-reset bubble, moves to FETCH unconditionally
// FETCH   |  1   | instruction request outstanding, ir_we on ack
// DECODE  |  2   | classify opcode, trap SYSTEM / unknown opcodes to HALT
// EXECUTE |  3   | ALU step; branch/fence commit PC here
// MEM     |  4   | data request outstanding (load or store)
// WB      |  5   | register write-back and PC commit
// HALT    |  6   | absorbing until reset

module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_fetch,
    output logic             ir_we,
    output logic             mdr_we,
    output logic             pc_we,
    output logic             rf_we,
    output logic [2:0]       state_o,
    output logic             halted,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Wait counter only needs to reach MEM_TIMEOUT-1; it saturates there.
    localparam int WC_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST =
        (MEM_TIMEOUT == 0) ? '0 : WC_W'(MEM_TIMEOUT - 1);

    state_t          state;
    state_t          next_state;
    logic [WC_W-1:0] wait_cnt;
    logic            set_illegal;
    logic            set_bus_err;
    logic            mem_wait;
    logic            timeout;

    logic is_load;
    logic is_store;
    logic is_brf;
    logic is_system;
    logic is_legal;

    // Opcode classification; only consulted in states where the IR is stable.
    always_comb begin
        is_load   = (opcode == OP_LOAD);
        is_store  = (opcode == OP_STORE);
        is_brf    = (opcode == OP_BRANCH) || (opcode == OP_FENCE);
        is_system = (opcode == OP_SYSTEM);
        is_legal  = is_load || is_store || is_brf || is_system ||
                    (opcode == OP_JAL)   || (opcode == OP_JALR) ||
                    (opcode == OP_IMM)   || (opcode == OP_REG)  ||
                    (opcode == OP_LUI)   || (opcode == OP_AUIPC);
    end

    // Watchdog fires on the last permitted wait cycle if ack is still absent;
    // an ack in that same cycle takes precedence.
    always_comb begin
        mem_wait = mem_req && !mem_ack;
        timeout  = (MEM_TIMEOUT != 0) && mem_wait && (wait_cnt == WAIT_LAST);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and sticky-flag set conditions.
    always_comb begin
        next_state  = state;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;
        case (state)
            S_IDLE: begin
                next_state = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ack) begin
                    next_state = S_DECODE;
                end else if (timeout) begin
                    next_state  = S_HALT;
                    set_bus_err = 1'b1;
                end
            end
            S_DECODE: begin
                if (is_system) begin
                    next_state = S_HALT;
                end else if (!is_legal) begin
                    next_state  = S_HALT;
                    set_illegal = 1'b1;
                end else begin
                    next_state = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (is_load || is_store) begin
                    next_state = S_MEM;
                end else if (is_brf) begin
                    next_state = S_FETCH;
                end else begin
                    next_state = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    next_state = is_store ? S_FETCH : S_WB;
                end else if (timeout) begin
                    next_state  = S_HALT;
                    set_bus_err = 1'b1;
                end
            end
            S_WB: begin
                next_state = S_FETCH;
            end
            S_HALT: begin
                next_state = S_HALT;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Output decode: request lines from state, enables qualified by ack/opcode.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_fetch = 1'b0;
        ir_we     = 1'b0;
        mdr_we    = 1'b0;
        pc_we     = 1'b0;
        rf_we     = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                mem_fetch = 1'b1;
                ir_we     = mem_ack;
            end
            S_EXECUTE: begin
                pc_we = is_brf;
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_store;
                pc_we   = mem_ack && is_store;
                mdr_we  = mem_ack && !is_store;
            end
            S_WB: begin
                pc_we = 1'b1;
                rf_we = (rd != 5'd0);
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_o = state;
        halted  = (state == S_HALT);
    end

    // Wait counter restarts whenever the state changes (i.e. on entry to a
    // request state) and counts un-acked request cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (next_state != state) begin
            wait_cnt <= '0;
        end else if (mem_wait && (wait_cnt != WAIT_LAST)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Sticky halt-cause flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            if (set_illegal) begin
                illegal <= 1'b1;
            end
            if (set_bus_err) begin
                bus_err <= 1'b1;
            end
        end
    end

    // Retired-instruction counter: one per PC commit, wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret <= '0;
        end else if (pc_we) begin
            instret <= instret + 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus randomized
// instruction streams with random memory wait states, checked per instruction
// against cycle-count / pulse-count expectations derived from the CPI rules.

module tb_multicycle_ctrl;

    localparam int TMO   = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [6:0]       opcode = '0;
    logic [4:0]       rd = '0;
    logic             mem_ack = 1'b0;
    logic             mem_req, mem_we, mem_fetch, ir_we, mdr_we, pc_we, rf_we;
    logic [2:0]       state_o;
    logic             halted, illegal, bus_err;
    logic [CNT_W-1:0] instret;

    int total = 0;
    int bad   = 0;
    int exp_instret = 0;

    logic [6:0] legal_ops [11] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
                                   7'b1100111, 7'b0010011, 7'b0110011, 7'b0110111,
                                   7'b0010111, 7'b0001111, 7'b1110011};
    logic [6:0] alu_ops [6] = '{7'b0010011, 7'b0110011, 7'b0110111,
                                7'b0010111, 7'b1101111, 7'b1100111};

    multicycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .rd(rd), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_fetch(mem_fetch),
        .ir_we(ir_we), .mdr_we(mdr_we), .pc_we(pc_we), .rf_we(rf_we),
        .state_o(state_o), .halted(halted), .illegal(illegal),
        .bus_err(bus_err), .instret(instret)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic bit in_list(input logic [6:0] op);
        for (int i = 0; i < 11; i++) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit is_alu(input logic [6:0] op);
        for (int i = 0; i < 6; i++) if (alu_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Assert reset now, check cleared outputs, release on a falling edge and
    // follow IDLE -> FETCH. Returns positioned in the first FETCH cycle.
    task automatic do_reset();
        rst = 1'b0;
        mem_ack = 1'b0;
        #1;
        chk("rst_outs", {mem_req, mem_we, mem_fetch, ir_we, mdr_we, pc_we, rf_we,
                         halted, illegal, bus_err}, 0);
        chk("rst_state", state_o, 0);
        chk("rst_instret", instret, 0);
        exp_instret = 0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("idle_state", state_o, 0);
        chk("idle_outs", {mem_req, mem_we, mem_fetch, ir_we, mdr_we, pc_we, rf_we,
                          halted, illegal, bus_err}, 0);
        @(posedge clk);
        #1;
        chk("post_idle_state", state_o, 1);
    endtask

    // HALT must absorb arbitrary ack/opcode activity.
    task automatic halt_hold();
        int npc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            mem_ack = 1'($urandom_range(0, 1));
            opcode  = 7'($urandom_range(0, 127));
            #1;
            npc += int'(pc_we) + int'(mem_req);
        end
        @(posedge clk);
        #1;
        chk("halt_hold_state", state_o, 6);
        chk("halt_hold_activity", npc, 0);
        chk("halt_hold_instret", instret, exp_instret % (1 << CNT_W));
    endtask

    // Run one instruction from its first FETCH cycle. fw/mw are the number of
    // wait cycles before ack for fetch and data access respectively.
    task automatic run_instr(input logic [6:0] op, input logic [4:0] r,
                             input int fw, input int mw);
        int cyc = 0, n_ir = 0, n_pc = 0, n_rf = 0, n_mdr = 0, n_we = 0, n_f = 0;
        int wcnt = 0;
        bit left = 0;
        int e_cyc = 0, e_ir = 0, e_pc = 0, e_rf = 0, e_mdr = 0, e_we = 0, e_f = 0;
        bit e_halt = 0, e_ill = 0, e_berr = 0;
        bit ld, st, brf, sys, alu, legal;

        ld    = (op == 7'b0000011);
        st    = (op == 7'b0100011);
        brf   = (op == 7'b1100011) || (op == 7'b0001111);
        sys   = (op == 7'b1110011);
        alu   = is_alu(op);
        legal = in_list(op);

        if (fw >= TMO) begin
            e_cyc = TMO; e_f = TMO; e_halt = 1; e_berr = 1;
        end else begin
            e_ir = 1;
            e_f  = fw + 1;
            if (!legal || sys) begin
                e_cyc = fw + 2; e_halt = 1; e_ill = !legal;
            end else if ((ld || st) && mw >= TMO) begin
                e_cyc = fw + 3 + TMO; e_halt = 1; e_berr = 1;
                if (st) e_we = TMO;
            end else begin
                e_pc = 1;
                if (alu) begin e_cyc = fw + 4; e_rf = (r != 0); end
                if (brf) e_cyc = fw + 3;
                if (st) begin e_cyc = fw + mw + 4; e_we = mw + 1; end
                if (ld) begin e_cyc = fw + mw + 5; e_mdr = 1; e_rf = (r != 0); end
            end
        end

        opcode = op;
        rd     = r;
        while (1) begin
            @(negedge clk);
            if (mem_req) mem_ack = (wcnt == (mem_fetch ? fw : mw)) ? 1'b1 : 1'b0;
            else         mem_ack = 1'($urandom_range(0, 1));
            #1;
            n_ir  += int'(ir_we);
            n_pc  += int'(pc_we);
            n_rf  += int'(rf_we);
            n_mdr += int'(mdr_we);
            n_we  += int'(mem_we);
            n_f   += int'(mem_fetch);
            if (mem_req && !mem_ack) wcnt++;
            else if (mem_req) wcnt = 0;
            cyc++;
            @(posedge clk);
            #1;
            if (state_o != 3'd1) left = 1;
            if (halted || (left && state_o == 3'd1) || cyc > 40) break;
        end
        mem_ack = 1'b0;
        if (e_pc != 0) exp_instret++;

        chk("cycles", cyc, e_cyc);
        chk("ir_we_cnt", n_ir, e_ir);
        chk("pc_we_cnt", n_pc, e_pc);
        chk("rf_we_cnt", n_rf, e_rf);
        chk("mdr_we_cnt", n_mdr, e_mdr);
        chk("mem_we_cnt", n_we, e_we);
        chk("fetch_cnt", n_f, e_f);
        chk("end_state", state_o, e_halt ? 6 : 1);
        chk("halted", halted, e_halt);
        chk("illegal", illegal, e_ill);
        chk("bus_err", bus_err, e_berr);
        chk("instret", instret, exp_instret % (1 << CNT_W));
        if (e_halt) begin
            halt_hold();
            do_reset();
        end
    endtask

    initial begin
        int n;
        logic [6:0] op;
        int cls, fw, mw;

        #12;
        do_reset();

        // Directed scenarios.
        run_instr(7'b0010011, 5'd1, 0, 0);   // ADDI x1, zero wait
        run_instr(7'b0000011, 5'd3, 0, 2);   // LOAD, 2 wait states in MEM
        run_instr(7'b0100011, 5'd5, 0, 0);   // STORE, rd field non-zero
        run_instr(7'b0010011, 5'd0, 0, 0);   // ADDI x0: no rf_we
        run_instr(7'b1100011, 5'd2, 0, 0);   // BRANCH
        run_instr(7'b0001111, 5'd0, 1, 0);   // FENCE, fetch wait
        run_instr(7'b0010011, 5'd7, 3, 0);   // ack on last permitted cycle
        run_instr(7'b0100011, 5'd1, 0, 3);   // STORE ack on last permitted cycle
        run_instr(7'b0000000, 5'd1, 0, 0);   // unknown opcode -> illegal
        run_instr(7'b1110011, 5'd0, 0, 0);   // ebreak -> halt, not illegal
        run_instr(7'b0010011, 5'd1, 4, 0);   // fetch timeout
        run_instr(7'b0000011, 5'd1, 0, 4);   // load timeout

        // Reset pulse while a data request is pending.
        opcode = 7'b0000011;
        rd = 5'd4;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            mem_ack = (mem_req && mem_fetch) ? 1'b1 : 1'b0;
            #1;
            if (state_o == 3'd4) begin
                n++;
                if (n == 2) break;
            end
        end
        chk("reach_mem", n, 2);
        chk("mem_req_pending", mem_req, 1);
        do_reset();
        run_instr(7'b0110011, 5'd9, 0, 0);

        // Randomized instruction stream; small CNT_W makes instret wrap.
        for (int k = 0; k < 80; k++) begin
            cls = $urandom_range(0, 9);
            fw  = ($urandom_range(0, 11) == 0) ? TMO : $urandom_range(0, 3);
            mw  = ($urandom_range(0, 11) == 0) ? TMO : $urandom_range(0, 3);
            case (cls)
                3: op = 7'b0000011;
                4: op = 7'b0100011;
                5: op = ($urandom_range(0, 1) != 0) ? 7'b1100011 : 7'b0001111;
                6: op = ($urandom_range(0, 3) == 0) ? 7'b1110011 : 7'b1100011;
                7: begin
                    if ($urandom_range(0, 2) == 0) begin
                        do op = 7'($urandom_range(0, 127)); while (in_list(op));
                    end else begin
                        op = 7'b0000011;
                    end
                end
                default: op = alu_ops[$urandom_range(0, 5)];
            endcase
            run_instr(op, 5'($urandom_range(0, 31)), fw, mw);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Sequencing controller for the multi-cycle version of the RV32I core. It replaces the single-cycle one-instruction-per-clock flow with an FSM that steps fetch, decode, execute, memory and writeback over several clocks.
- Fetch and data accesses share one memory port through a req/ack handshake.
- Emits register/PC write enables, a watchdog bus error, a halt indication and a retired-instruction counter.
- Sits beside the datapath: it takes opcode/rd from the instruction register and drives the datapath enables.

Parameters:
MEM_TIMEOUT, 16, max cycles mem_req may wait for mem_ack before bus error; 0 disables watchdog
CNT_W, 32, width of instret counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
opcode  in  7  instr[6:0] from instruction register
rd  in  5  instr[11:7] from instruction register
mem_ack  in  1  memory completes current request this cycle
mem_req  out  1  memory request
mem_we  out  1  write request (store); valid with mem_req
mem_fetch  out  1  request is instruction fetch
ir_we  out  1  latch instruction register
mdr_we  out  1  latch load data register
pc_we  out  1  commit NextPC into pc
rf_we  out  1  register file write
state_o  out  3  current FSM state
halted  out  1  FSM in HALT
illegal  out  1  sticky: halted on unknown opcode
bus_err  out  1  sticky: halted on memory timeout
instret  out  CNT_W  retired instruction count

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, HALT=6.
- Reset (rst=0, async):
  - state=IDLE, counters=0, illegal=bus_err=0.
  - All outputs 0 while in reset and in IDLE.
- IDLE: unconditionally → FETCH next cycle.
- FETCH:
  - mem_req=1, mem_fetch=1, mem_we=0.
  - On mem_ack: ir_we=1 in the same cycle (combinational), → DECODE.
  - Without ack: stay.
- DECODE (1 cycle):
  - SYSTEM (1110011) → HALT.
  - Opcode not in {LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, OP-IMM 0010011, OP 0110011, LUI 0110111, AUIPC 0010111, FENCE 0001111, SYSTEM} → HALT and set illegal.
  - Otherwise → EXECUTE.
- EXECUTE (1 cycle):
  - LOAD/STORE → MEM.
  - BRANCH/FENCE: pc_we=1 (branch decision made in datapath), → FETCH.
  - All others → WB.
- MEM:
  - mem_req=1, mem_fetch=0, mem_we=1 for STORE else 0.
  - On mem_ack, STORE: pc_we=1, → FETCH.
  - On mem_ack, LOAD: mdr_we=1, → WB.
- WB (1 cycle): rf_we=(rd!=0), pc_we=1, → FETCH.
- HALT:
  - Absorbing until reset; halted=1, all enables 0.
  - opcode/mem_ack ignored.
- Handshake rules:
  - Zero-wait ack (ack in the first cycle of FETCH/MEM) is accepted.
  - mem_ack while mem_req=0 is ignored.
  - mem_req and mem_we are held stable until ack.
  - opcode/rd are sampled only in DECODE/EXECUTE/MEM/WB (IR stable after ir_we).
- Watchdog:
  - wait_cnt clears on entering FETCH/MEM and increments each cycle mem_req=1 && !mem_ack.
  - If MEM_TIMEOUT!=0 and wait_cnt reaches MEM_TIMEOUT-1 with no ack: → HALT next cycle, set bus_err.
  - Ack in that same cycle wins: normal transition, no error.
- instret:
  - Increments by 1 on every cycle pc_we=1.
  - Wraps modulo 2^CNT_W.
  - HALT does not increment.
- Reset asserted mid-operation (e.g. MEM with req pending): immediately IDLE, mem_req drops asynchronously, flags cleared.
- Cycles per instruction at zero wait:
  - ALU/JAL/JALR/LUI/AUIPC: 4
  - LOAD: 5
  - STORE: 4
  - BRANCH/FENCE: 3

Test Plan:
- ADDI x1 (opcode 0010011, rd=1), mem_ack tied 1 → states 1,2,3,5 repeating; ir_we in FETCH; rf_we=1 and pc_we=1 in WB; instret=1 after 5 clocks from reset release.
- LOAD with 2 wait-state ack in MEM → mem_req=1, mem_we=0 for 3 MEM cycles; mdr_we pulse on 3rd; rf_we in WB; 7 cycles FETCH→FETCH.
- STORE rd field=5, zero wait → mem_we=1 in MEM, pc_we on ack, rf_we never asserted; ADDI with rd=0 → rf_we=0 in WB, pc_we=1.
- opcode 0000000 → HALT after DECODE, illegal=1, halted=1, instret unchanged; ebreak (1110011) → HALT, illegal=0.
- MEM_TIMEOUT=4, mem_ack held 0 in FETCH → HALT after 4 request cycles, bus_err=1; repeat with ack on 4th cycle → DECODE, bus_err=0.
- Pulse rst low during MEM wait → mem_req=0 immediately, state_o=0; after release, IDLE then FETCH with instret=0.
